// File: rtl/video_source_switch_if.sv
// rtl/video_source_switch_if.sv - request, per-source video and selected-output bundle for video_source_switch
interface video_source_switch_if #(
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic [SEL_W-1:0]       sel_req;
    logic                   sel_req_valid;
    logic                   sel_req_ready;

    logic [24*NUM_SRC-1:0]  src_rgb;
    logic [NUM_SRC-1:0]     src_de;
    logic [NUM_SRC-1:0]     src_skip;
    logic [NUM_SRC-1:0]     src_vs;
    logic [NUM_SRC-1:0]     src_hs;

    logic [23:0]            out_rgb;
    logic                   out_de;
    logic                   out_skip;
    logic                   out_vs;
    logic                   out_hs;

    logic [SEL_W-1:0]       active_sel;
    logic                   switching;
    logic                   align_timeout;

    modport master (
        output sel_req, sel_req_valid,
        output src_rgb, src_de, src_skip, src_vs, src_hs,
        input  sel_req_ready,
        input  out_rgb, out_de, out_skip, out_vs, out_hs,
        input  active_sel, switching, align_timeout
    );

    modport slave (
        input  sel_req, sel_req_valid,
        input  src_rgb, src_de, src_skip, src_vs, src_hs,
        output sel_req_ready,
        output out_rgb, out_de, out_skip, out_vs, out_hs,
        output active_sel, switching, align_timeout
    );
endinterface

// File: rtl/video_source_switch.sv
// rtl/video_source_switch.sv - frame-synchronous N:1 video source selector with black-frame insertion
module video_source_switch #(
    parameter int NUM_SRC       = 2,
    parameter int SEL_W         = $clog2(NUM_SRC),
    parameter int BLANK_FRAMES  = 1,
    parameter int ALIGN_TIMEOUT = 2000000
) (
    input  logic                rgb_clock,
    input  logic                reset,
    video_source_switch_if.slave bus
);
    localparam int BLANK_W = $clog2(BLANK_FRAMES + 1);
    localparam int TMO_W   = $clog2(ALIGN_TIMEOUT + 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_FRAMES);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(ALIGN_TIMEOUT - 1);
    localparam logic [SEL_W:0]     SRC_LIMIT  = (SEL_W + 1)'(NUM_SRC);

    typedef enum logic [1:0] {
        ST_PASS,
        ST_DRAIN,
        ST_BLANK,
        ST_ALIGN
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   active_q, active_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               timeout_q, timeout_d;
    logic [NUM_SRC-1:0] vs_prev_q;

    logic [23:0] out_rgb_q, out_rgb_d;
    logic        out_de_q, out_de_d;
    logic        out_skip_q, out_skip_d;
    logic        out_vs_q, out_vs_d;
    logic        out_hs_q, out_hs_d;

    logic [NUM_SRC-1:0] vs_rise;
    logic [23:0] old_rgb, tgt_rgb;
    logic        old_de, old_skip, old_vs, old_hs, old_rise;
    logic        tgt_de, tgt_skip, tgt_vs, tgt_hs, tgt_rise;
    logic        req_fire, req_new;

    assign vs_rise = bus.src_vs & ~vs_prev_q;

    // Two views of the source bank: the one on air now and the one being switched to.
    always_comb begin
        old_rgb  = '0;
        old_de   = 1'b0;
        old_skip = 1'b0;
        old_vs   = 1'b0;
        old_hs   = 1'b0;
        old_rise = 1'b0;
        tgt_rgb  = '0;
        tgt_de   = 1'b0;
        tgt_skip = 1'b0;
        tgt_vs   = 1'b0;
        tgt_hs   = 1'b0;
        tgt_rise = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active_q == SEL_W'(i)) begin
                old_rgb  = bus.src_rgb[24*i +: 24];
                old_de   = bus.src_de[i];
                old_skip = bus.src_skip[i];
                old_vs   = bus.src_vs[i];
                old_hs   = bus.src_hs[i];
                old_rise = vs_rise[i];
            end
            if (target_q == SEL_W'(i)) begin
                tgt_rgb  = bus.src_rgb[24*i +: 24];
                tgt_de   = bus.src_de[i];
                tgt_skip = bus.src_skip[i];
                tgt_vs   = bus.src_vs[i];
                tgt_hs   = bus.src_hs[i];
                tgt_rise = vs_rise[i];
            end
        end
    end

    assign bus.sel_req_ready = (state_q == ST_PASS) & ~reset;
    assign req_fire = bus.sel_req_valid & bus.sel_req_ready;
    assign req_new  = ({1'b0, bus.sel_req} < SRC_LIMIT) && (bus.sel_req != active_q);

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        target_d    = target_q;
        blank_cnt_d = blank_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = timeout_q;
        out_rgb_d   = '0;
        out_de_d    = 1'b0;
        out_skip_d  = 1'b0;
        out_vs_d    = 1'b0;
        out_hs_d    = 1'b0;

        unique case (state_q)
            ST_PASS: begin
                out_rgb_d  = old_rgb;
                out_de_d   = old_de;
                out_skip_d = old_skip;
                out_vs_d   = old_vs;
                out_hs_d   = old_hs;
                if (req_fire && req_new) begin
                    target_d = bus.sel_req;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_vs_d = old_vs;
                out_hs_d = old_hs;
                if (old_rise) begin
                    blank_cnt_d = BLANK_W'(1);
                    state_d     = ST_BLANK;
                end else begin
                    out_rgb_d  = old_rgb;
                    out_de_d   = old_de;
                    out_skip_d = old_skip;
                end
            end
            ST_BLANK: begin
                // Sync keeps following the old source so the sink still sees frame timing.
                out_vs_d = old_vs;
                out_hs_d = old_hs;
                if (old_rise) begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        state_d   = ST_ALIGN;
                        tmo_cnt_d = '0;
                        out_vs_d  = 1'b0;
                        out_hs_d  = 1'b0;
                    end else begin
                        blank_cnt_d = blank_cnt_q + BLANK_W'(1);
                    end
                end
            end
            ST_ALIGN: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (tgt_rise) begin
                    active_d   = target_q;
                    state_d    = ST_PASS;
                    out_rgb_d  = tgt_rgb;
                    out_de_d   = tgt_de;
                    out_skip_d = tgt_skip;
                    out_vs_d   = tgt_vs;
                    out_hs_d   = tgt_hs;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    active_d  = target_q;
                    state_d   = ST_PASS;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    always_ff @(posedge rgb_clock) begin
        vs_prev_q <= reset ? '0 : bus.src_vs;
        if (reset) begin
            state_q     <= ST_PASS;
            active_q    <= '0;
            target_q    <= '0;
            blank_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            out_rgb_q   <= '0;
            out_de_q    <= 1'b0;
            out_skip_q  <= 1'b0;
            out_vs_q    <= 1'b0;
            out_hs_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            target_q    <= target_d;
            blank_cnt_q <= blank_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
            out_rgb_q   <= out_rgb_d;
            out_de_q    <= out_de_d;
            out_skip_q  <= out_skip_d;
            out_vs_q    <= out_vs_d;
            out_hs_q    <= out_hs_d;
        end
    end

    assign bus.out_rgb       = out_rgb_q;
    assign bus.out_de        = out_de_q;
    assign bus.out_skip      = out_skip_q;
    assign bus.out_vs        = out_vs_q;
    assign bus.out_hs        = out_hs_q;
    assign bus.active_sel    = active_q;
    assign bus.switching     = (state_q != ST_PASS);
    assign bus.align_timeout = timeout_q;
endmodule
